// File: rtl/prog_mem_loader_if.sv
// Bus bundle for prog_mem_loader: program-load stream in, instruction-fetch port out.
// master = the side feeding program words and issuing fetches; slave = the loader.
interface prog_mem_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   words_loaded;
  logic              running;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, load_done, words_loaded, running, fetch_valid, fetch_data, fetch_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, load_done, words_loaded, running, fetch_valid, fetch_data, fetch_err
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory loader: streams a program into a RAM (IDLE/LOAD/RUN FSM), then serves
// single-cycle-latency instruction fetches while running.
module prog_mem_loader #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 8,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  prog_mem_loader_if.slave   bus,
  output logic [1:0]         state_dbg
);
  // Handshake: a load word transfers on any cycle where load_valid && load_ready are both
  // high at the rising edge; load_ready is high exactly in LOAD and never depends on
  // load_valid. load_start has priority over a word in the same cycle (the word is dropped).
  // A fetch is a single-cycle request; the answer (fetch_valid or fetch_err) arrives one cycle later.

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e            state, state_nxt;
  logic [ADDR_W:0]   words_loaded, wl_nxt;
  logic              we;
  logic              fetch_ok, fetch_bad;
  logic              load_done_q, fetch_valid_q, fetch_err_q, hit_q;
  logic [DATA_W-1:0] rd_q, hold_q, fetch_data;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      words_loaded  <= '0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      hit_q         <= 1'b0;
      hold_q        <= DEFAULT_WORD;
    end else begin
      state         <= state_nxt;
      words_loaded  <= wl_nxt;
      load_done_q   <= (state == LOAD) && (state_nxt == RUN);
      fetch_valid_q <= fetch_ok;
      fetch_err_q   <= fetch_bad;
      hit_q         <= {1'b0, bus.fetch_addr} < words_loaded;
      hold_q        <= fetch_data;
    end
  end

  // Plain RAM: no reset, one write port, registered read every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[words_loaded[ADDR_W-1:0]] <= bus.load_data;
    rd_q <= mem[bus.fetch_addr];
  end

  always_comb begin
    state_nxt = state;
    wl_nxt    = words_loaded;
    we        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nxt = LOAD;
          wl_nxt    = '0;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          wl_nxt = '0;
        end else if (bus.load_valid) begin
          we     = !rst;
          wl_nxt = words_loaded + 1'b1;
          // The final RAM slot closes the load even without load_last, so the count stops at DEPTH.
          if (bus.load_last || words_loaded == LAST_IDX) state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_nxt = LOAD;
          wl_nxt    = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_ok  = bus.fetch_req && (state == RUN) && !bus.load_start;
  assign fetch_bad = bus.fetch_req && !fetch_ok;

  // Addresses at or beyond the loaded length read as DEFAULT_WORD; between fetches the last value holds.
  assign fetch_data = fetch_valid_q ? (hit_q ? rd_q : DEFAULT_WORD) : hold_q;

  assign bus.load_ready   = (state == LOAD);
  assign bus.load_done    = load_done_q;
  assign bus.words_loaded = words_loaded;
  assign bus.running      = (state == RUN);
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.fetch_data   = fetch_data;
  assign bus.fetch_err    = fetch_err_q;
  assign state_dbg        = state;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: a default 16x256 instance and a 4-word (ADDR_W=2) instance.
module tb_prog_mem_loader;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_a, state_b;
  int         errors = 0;
  int         checks = 0;

  prog_mem_loader_if #(.DATA_W(16), .ADDR_W(8)) bus_a ();
  prog_mem_loader_if #(.DATA_W(16), .ADDR_W(2)) bus_b ();

  prog_mem_loader #(.DATA_W(16), .ADDR_W(8), .DEFAULT_WORD(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a)
  );
  prog_mem_loader #(.DATA_W(16), .ADDR_W(2), .DEFAULT_WORD(16'h0000)) u_small (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b)
  );

  always #5 clk = ~clk;

  logic [15:0] prog [13] = '{16'h1005, 16'h1407, 16'h1801, 16'h0811, 16'h0821, 16'h7100, 16'hC100,
                             16'h500A, 16'hE00C, 16'h500C, 16'h1455, 16'h400C, 16'hF000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_a.load_start = 0; bus_a.load_valid = 0; bus_a.load_data = '0; bus_a.load_last = 0;
    bus_a.fetch_req = 0; bus_a.fetch_addr = '0;
    bus_b.load_start = 0; bus_b.load_valid = 0; bus_b.load_data = '0; bus_b.load_last = 0;
    bus_b.fetch_req = 0; bus_b.fetch_addr = '0;
  endtask

  task automatic fetch_a(input logic [7:0] addr, input string tag, input logic [15:0] exp);
    bus_a.fetch_req = 1; bus_a.fetch_addr = addr;
    tick();
    check({tag, "_valid"}, bus_a.fetch_valid, 1);
    check({tag, "_data"}, bus_a.fetch_data, exp);
  endtask

  initial begin
    idle_inputs();
    tick(); tick();
    // Reset state
    check("rst_state", state_a, S_IDLE);
    check("rst_ready", bus_a.load_ready, 0);
    check("rst_done", bus_a.load_done, 0);
    check("rst_running", bus_a.running, 0);
    check("rst_fvalid", bus_a.fetch_valid, 0);
    check("rst_ferr", bus_a.fetch_err, 0);
    check("rst_words", bus_a.words_loaded, 0);
    check("rst_fdata", bus_a.fetch_data, 16'h0000);
    rst = 0;

    // Fetch in IDLE is rejected
    bus_a.fetch_req = 1; bus_a.fetch_addr = 8'h05;
    tick();
    bus_a.fetch_req = 0;
    check("idle_ferr", bus_a.fetch_err, 1);
    check("idle_fvalid", bus_a.fetch_valid, 0);
    check("idle_fdata", bus_a.fetch_data, 16'h0000);
    tick();
    check("idle_ferr_clear", bus_a.fetch_err, 0);

    // 13-word program with load_last on the final word
    bus_a.load_start = 1;
    tick();
    bus_a.load_start = 0;
    check("load_state", state_a, S_LOAD);
    check("load_ready", bus_a.load_ready, 1);
    for (int i = 0; i < 13; i++) begin
      bus_a.load_valid = 1; bus_a.load_data = prog[i]; bus_a.load_last = (i == 12);
      tick();
      if (i < 12) check("load_done_early", bus_a.load_done, 0);
    end
    bus_a.load_valid = 0; bus_a.load_last = 0;
    check("p13_words", bus_a.words_loaded, 13);
    check("p13_done", bus_a.load_done, 1);
    check("p13_running", bus_a.running, 1);
    check("p13_ready", bus_a.load_ready, 0);
    // A word offered in RUN is ignored
    bus_a.load_valid = 1; bus_a.load_data = 16'hFFFF;
    tick();
    bus_a.load_valid = 0;
    check("p13_done_single", bus_a.load_done, 0);
    check("run_ignore_words", bus_a.words_loaded, 13);
    check("run_ignore_state", state_a, S_RUN);

    // Back-to-back fetches, hold, then out-of-range
    fetch_a(8'h00, "f00", 16'h1005);
    fetch_a(8'h07, "f07", 16'h500A);
    fetch_a(8'h0C, "f0c", 16'hF000);
    bus_a.fetch_req = 0;
    tick();
    check("hold_valid", bus_a.fetch_valid, 0);
    check("hold_data", bus_a.fetch_data, 16'hF000);
    fetch_a(8'h0D, "f0d", 16'h0000);
    fetch_a(8'h05, "f05", 16'h7100);

    // load_start beats a simultaneous fetch
    bus_a.fetch_req = 1; bus_a.fetch_addr = 8'h00; bus_a.load_start = 1;
    tick();
    bus_a.fetch_req = 0; bus_a.load_start = 0;
    check("collide_state", state_a, S_LOAD);
    check("collide_ferr", bus_a.fetch_err, 1);
    check("collide_fvalid", bus_a.fetch_valid, 0);
    check("collide_words", bus_a.words_loaded, 0);
    check("collide_fdata", bus_a.fetch_data, 16'h7100);

    // load_valid toggling, then restart mid-load
    bus_a.load_valid = 1; bus_a.load_data = 16'hAAAA; tick();
    bus_a.load_valid = 0; bus_a.load_data = 16'hBBBB; tick();
    bus_a.load_valid = 1; bus_a.load_data = 16'hCCCC; tick();
    bus_a.load_valid = 0; tick();
    check("toggle_words", bus_a.words_loaded, 2);
    bus_a.load_start = 1; tick();
    bus_a.load_start = 0;
    check("restart_words", bus_a.words_loaded, 0);
    check("restart_state", state_a, S_LOAD);
    bus_a.load_valid = 1; bus_a.load_data = 16'h5555; bus_a.load_last = 1; tick();
    bus_a.load_valid = 0; bus_a.load_last = 0;
    check("restart_running", bus_a.running, 1);
    check("restart_len", bus_a.words_loaded, 1);
    fetch_a(8'h00, "restart_f0", 16'h5555);
    fetch_a(8'h01, "restart_f1", 16'h0000);
    bus_a.fetch_req = 0;

    // Reset mid-load with a word and a fetch also presented
    bus_a.load_start = 1; tick();
    bus_a.load_start = 0;
    for (int i = 0; i < 3; i++) begin
      bus_a.load_valid = 1; bus_a.load_data = 16'h0100 + 16'(i); tick();
    end
    check("pre_rst_words", bus_a.words_loaded, 3);
    rst = 1; bus_a.load_data = 16'h9999; bus_a.fetch_req = 1;
    tick();
    rst = 0; bus_a.load_valid = 0; bus_a.fetch_req = 0;
    check("mid_rst_state", state_a, S_IDLE);
    check("mid_rst_ready", bus_a.load_ready, 0);
    check("mid_rst_words", bus_a.words_loaded, 0);
    check("mid_rst_fvalid", bus_a.fetch_valid, 0);
    check("mid_rst_ferr", bus_a.fetch_err, 0);
    bus_a.load_start = 1; tick();
    bus_a.load_start = 0;
    bus_a.load_valid = 1; bus_a.load_data = 16'h1234; bus_a.load_last = 1; tick();
    bus_a.load_valid = 0; bus_a.load_last = 0;
    check("post_rst_words", bus_a.words_loaded, 1);
    check("post_rst_done", bus_a.load_done, 1);
    fetch_a(8'h01, "post_rst_f1", 16'h0000);
    fetch_a(8'h00, "post_rst_f0", 16'h1234);
    bus_a.fetch_req = 0;

    // 4-word RAM fills without load_last and completes by itself
    bus_b.load_start = 1; tick();
    bus_b.load_start = 0;
    for (int i = 0; i < 4; i++) begin
      bus_b.load_valid = 1; bus_b.load_data = 16'h000A + 16'(i); bus_b.load_last = 0;
      tick();
      if (i < 3) check("small_not_running", bus_b.running, 0);
    end
    bus_b.load_valid = 0;
    check("small_words", bus_b.words_loaded, 4);
    check("small_done", bus_b.load_done, 1);
    check("small_state", state_b, S_RUN);
    bus_b.fetch_req = 1; bus_b.fetch_addr = 2'd3; tick();
    check("small_f3_valid", bus_b.fetch_valid, 1);
    check("small_f3_data", bus_b.fetch_data, 16'h000D);
    bus_b.fetch_addr = 2'd0; tick();
    bus_b.fetch_req = 0;
    check("small_f0_data", bus_b.fetch_data, 16'h000A);
    tick();
    check("small_done_single", bus_b.load_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width.
REQ-002 Parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter DEFAULT_WORD, default 16'h0000 (DATA_W wide), value returned for unloaded addresses.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_start  input  1  one-cycle pulse that begins a new program load.
REQ-007 load_valid  input  1  load_data holds a valid word.
REQ-008 load_data  input  DATA_W  program word to store.
REQ-009 load_last  input  1  marks the final word of the load; qualified by load_valid.
REQ-010 load_ready  output  1  block accepts a load word this cycle.
REQ-011 load_done  output  1  one-cycle pulse when a load completes.
REQ-012 words_loaded  output  ADDR_W+1  number of valid words stored.
REQ-013 running  output  1  block is in RUN state; fetches are serviced.
REQ-014 fetch_req  input  1  fetch request for fetch_addr.
REQ-015 fetch_addr  input  ADDR_W  fetch address.
REQ-016 fetch_valid  output  1  fetch_data is valid this cycle (one-cycle pulse).
REQ-017 fetch_data  output  DATA_W  fetched word; holds its value between fetches.
REQ-018 fetch_err  output  1  one-cycle pulse: the fetch was rejected.

Function
REQ-019 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-020 IDLE -> LOAD, and RUN -> LOAD, on load_start; load_start in LOAD SHALL restart the load, with the write pointer and words_loaded cleared to 0.
REQ-021 load_ready SHALL be 1 exactly when the state is LOAD.
REQ-022 Word accept is load_valid && load_ready: write load_data to mem[wr_ptr], then increment wr_ptr and words_loaded by 1.
REQ-023 An accepted word with load_last=1 SHALL move LOAD -> RUN in the next cycle.
REQ-024 Accepting word index DEPTH-1 SHALL force LOAD -> RUN regardless of load_last; words_loaded = DEPTH and does not wrap.
REQ-025 load_done SHALL pulse high for exactly one cycle, in the first cycle of RUN.
REQ-026 Any load_valid cycle while load_ready=0 SHALL be ignored, with no state change.
REQ-027 In RUN, fetch_req SHALL produce fetch_valid=1 on the next cycle (1-cycle latency), with fetch_data = mem[fetch_addr] if fetch_addr < words_loaded, else DEFAULT_WORD.
REQ-028 Back-to-back fetch_req every cycle SHALL be fully pipelined: one result per cycle, in order.
REQ-029 A fetch_req outside RUN SHALL give fetch_err=1 on the next cycle, with fetch_valid=0 and fetch_data unchanged.
REQ-030 fetch_req together with load_start in RUN: load_start wins, the state goes to LOAD and the fetch gets fetch_err.
REQ-031 running SHALL equal (state == RUN).
REQ-032 Memory contents SHALL be inferable as synchronous-write/synchronous-read RAM; contents are not cleared by reset.

Reset
REQ-033 On rst: state=IDLE, wr_ptr=0, words_loaded=0, and load_ready, load_done, running, fetch_valid and fetch_err all 0.
REQ-034 On rst: fetch_data = DEFAULT_WORD.
REQ-035 rst SHALL override all other inputs in the same cycle, including mid-load and mid-fetch.
REQ-036 After rst, stale memory SHALL be unreadable: a fetch must be preceded by a new load (see REQ-027 and REQ-029).

Verification
REQ-037 Load 13 words 0x1005,0x1407,0x1801,0x0811,0x0821,0x7100,0xC100,0x500A,0xE00C,0x500C,0x1455,0x400C,0xF000, with load_last on the 13th -> words_loaded=13, a single load_done pulse, running=1.
REQ-038 After REQ-037, fetch 0x00, 0x07, 0x0C on consecutive cycles -> fetch_valid=1 for 3 cycles, fetch_data 0x1005, 0x500A, 0xF000; then fetch 0x0D -> 0x0000.
REQ-039 ADDR_W=2, 4 words 0xA,0xB,0xC,0xD with no load_last -> auto-complete after the 4th word, words_loaded=4, load_done pulses; fetch 3 -> 0xD.
REQ-040 fetch_req in IDLE right after reset -> fetch_err=1 next cycle, fetch_valid=0, fetch_data=0x0000.
REQ-041 rst asserted after 3 accepted words -> next cycle state IDLE, load_ready=0, words_loaded=0; a new load of 1 word 0x1234 (last) then fetch 1 -> 0x0000.
REQ-042 load_valid toggled 1,0,1,0 during LOAD and load_start asserted mid-load -> only valid cycles write; the restart clears words_loaded to 0 and the next word lands at address 0.
